ysyx_24080014_lsu: RTL
======================

// Module: ysyx_24080014_lsu
// PURPOSE
//   Load/store unit between execute and the writeback rd-select mux. Takes one memory op per handshake,
//   runs it on a simplified AXI4-Lite master port, and returns aligned, extended load data.
//   Load data feeds the writeback mux's READ_DATA input. Store writes return read_data=0.
//   Holds at most one op in flight. Misaligned accesses, bad funct3, bus errors and timeouts raise out_err.
// PARAMETERS
//   TIMEOUT_CYC  255  cycles allowed in any bus-wait state before the op is aborted with out_err=1.
// PORTS
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   in_valid       in   1   execute presents an op
//   in_ready       out  1   LSU can accept an op; high only in IDLE
//   in_load        in   1   op is a load
//   in_store       in   1   op is a store; in_load and in_store are never both 1
//   in_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only
//   in_addr        in   32  byte address from the ALU
//   in_wdata       in   32  store data (rs2), right-aligned
//   out_valid      out  1   result valid; held until out_ready
//   out_ready      in   1   downstream consumes the result
//   read_data      out  32  extended load data; 0 for stores, errors and no-ops
//   out_err        out  1   the op faulted
//   araddr/arvalid/arready   out/out/in  32/1/1  read address channel; araddr={addr[31:2],2'b00}
//   rdata/rresp/rvalid/rready in/in/in/out 32/2/1/1  read data channel
//   awaddr/awvalid/awready   out/out/in  32/1/1  write address channel; word-aligned like araddr
//   wdata/wstrb/wvalid/wready out/out/out/in 32/4/1/1  write data channel
//   bresp/bvalid/bready      in/in/out   2/1/1  write response channel
// BEHAVIOUR
//   - States: IDLE, AR, R, AWW, B, RESP. All bus valids and readies decode from state and the AWW
//     done-flags only (Moore outputs). There is no combinational path from bus inputs to bus outputs.
//   - Reset (async, mid-op included): state=IDLE, in_ready=1, every valid/ready/err output=0,
//     read_data=0, timeout counter=0. Any in-flight transaction is abandoned.
//   - IDLE: if in_valid, latch op fields, then:
//     misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 -> RESP, err=1;
//     load -> AR; store -> AWW; neither load nor store -> RESP, err=0, no bus access.
//   - AR: arvalid=1 until arready, then go to R. R: rready=1; on rvalid -> RESP.
//   - Load extraction: shift rdata right by 8*addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
//   - Load error: rresp!=0 -> err=1, read_data=0.
//   - AWW: awvalid and wvalid rise together. Each drops independently after its own handshake.
//     When both have completed (same or different cycles) -> B. B: bready=1; on bvalid -> RESP; err=(bresp!=0).
//   - Store lanes: SB wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}},
//     wstrb=4'b0011<<addr[1:0]; SW wdata=d, wstrb=4'b1111.
//   - Timeout: the counter clears when AR or AWW is entered and counts every cycle in AR/R/AWW/B.
//     At TIMEOUT_CYC -> RESP, err=1, and all bus valids/readies drop the next cycle.
//   - RESP: out_valid=1; read_data and out_err stay stable until out_ready, then go to IDLE.
//     in_ready is low in RESP, so there is at least one bubble between ops.
//   - Latency: with zero-wait memory (arready=1, rvalid the cycle after AR), accept at cycle 0,
//     AR at 1, R at 2, out_valid at 3. A store has the same shape through AWW/B.
// TESTING
//   LB addr=0x80000003, rdata=0x80FF_1234 -> araddr=0x80000000, read_data=0xFFFF_FF80, err=0
//   LHU addr=0x80000002, rdata=0xBEEF_0000 -> read_data=0x0000_BEEF; with rresp=2'b10 -> err=1, read_data=0
//   SB addr=0x10, d=0xAB; awready 2 cycles before wready -> wdata=0xABAB_ABAB, wstrb=4'b0001, single B handshake
//   LW addr=0x2 -> err=1 at out_valid, no arvalid ever asserted; SH addr=0x1 -> err=1, no awvalid
//   out_ready held low 5 cycles -> out_valid/read_data stable all 5 cycles, in_ready stays 0
//   arready stuck at 0 -> out_valid with err=1 after TIMEOUT_CYC; rst_n pulsed low during R -> all outputs at reset values

Source files
------------

// File: rtl/ysyx_24080014_lsu_if.sv
// Simplified AXI4-Lite bus between the LSU (master) and memory (slave).
interface ysyx_24080014_lsu_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one op in flight over an AXI4-Lite master port, returns aligned
// and extended load data with fault reporting (misalign, bad funct3, bus error, timeout).
module ysyx_24080014_lsu #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] read_data,
   output logic        out_err,
   ysyx_24080014_lsu_if.master bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

   state_t           state, state_nx;
   logic [2:0]       op_f3;
   logic [31:0]      op_addr;
   logic [31:0]      op_wdata;
   logic [3:0]       op_wstrb;
   logic             aw_done, w_done;
   logic [CNT_W-1:0] cnt;

   logic        f3_ok_c, mis_c, bad_c, to_hit_c, aw_fin_c, w_fin_c;
   logic [31:0] st_wdata_c, shifted_c, ext_c;
   logic [3:0]  st_wstrb_c;

   // Op legality check on the presented (not yet latched) op.
   always_comb begin
      f3_ok_c = 1'b0;
      mis_c   = 1'b0;
      case (in_funct3)
         3'b000:  f3_ok_c = 1'b1;
         3'b001:  begin f3_ok_c = 1'b1;    mis_c = in_addr[0];    end
         3'b010:  begin f3_ok_c = 1'b1;    mis_c = |in_addr[1:0]; end
         3'b100:  f3_ok_c = in_load;
         3'b101:  begin f3_ok_c = in_load; mis_c = in_addr[0];    end
         default: f3_ok_c = 1'b0;
      endcase
      bad_c = (in_load | in_store) & (~f3_ok_c | mis_c);
   end

   // Store lane replication and byte strobes.
   always_comb begin
      case (in_funct3[1:0])
         2'b00: begin
            st_wdata_c = {4{in_wdata[7:0]}};
            st_wstrb_c = 4'b0001 << in_addr[1:0];
         end
         2'b01: begin
            st_wdata_c = {2{in_wdata[15:0]}};
            st_wstrb_c = 4'b0011 << in_addr[1:0];
         end
         default: begin
            st_wdata_c = in_wdata;
            st_wstrb_c = 4'b1111;
         end
      endcase
   end

   // Load data alignment and extension.
   always_comb begin
      shifted_c = bus.rdata >> {op_addr[1:0], 3'b000};
      case (op_f3)
         3'b000:  ext_c = {{24{shifted_c[7]}},  shifted_c[7:0]};
         3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  ext_c = {24'h0, shifted_c[7:0]};
         3'b101:  ext_c = {16'h0, shifted_c[15:0]};
         default: ext_c = shifted_c;
      endcase
   end

   assign to_hit_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign aw_fin_c = aw_done | (bus.awvalid & bus.awready);
   assign w_fin_c  = w_done  | (bus.wvalid  & bus.wready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid) begin
            if (bad_c || !(in_load || in_store)) state_nx = RESP;
            else if (in_load)                    state_nx = AR;
            else                                 state_nx = AWW;
         end
         AR:   if (bus.arready)              state_nx = R;
               else if (to_hit_c)            state_nx = RESP;
         R:    if (bus.rvalid || to_hit_c)   state_nx = RESP;
         AWW:  if (aw_fin_c && w_fin_c)      state_nx = B;
               else if (to_hit_c)            state_nx = RESP;
         B:    if (bus.bvalid || to_hit_c)   state_nx = RESP;
         RESP: if (out_ready)                state_nx = IDLE;
         default:                            state_nx = IDLE;
      endcase
   end

   // Moore decode: bus handshakes depend only on state and the AWW done-flags.
   always_comb begin
      in_ready    = (state == IDLE);
      out_valid   = (state == RESP);
      bus.arvalid = (state == AR);
      bus.rready  = (state == R);
      bus.awvalid = (state == AWW) && !aw_done;
      bus.wvalid  = (state == AWW) && !w_done;
      bus.bready  = (state == B);
   end

   assign bus.araddr = {op_addr[31:2], 2'b00};
   assign bus.awaddr = {op_addr[31:2], 2'b00};
   assign bus.wdata  = op_wdata;
   assign bus.wstrb  = op_wstrb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_f3     <= 3'b000;
         op_addr   <= 32'h0;
         op_wdata  <= 32'h0;
         op_wstrb  <= 4'h0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         cnt       <= '0;
         read_data <= 32'h0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_f3     <= in_funct3;
               op_addr   <= in_addr;
               op_wdata  <= st_wdata_c;
               op_wstrb  <= st_wstrb_c;
               aw_done   <= 1'b0;
               w_done    <= 1'b0;
               cnt       <= '0;
               read_data <= 32'h0;
               out_err   <= bad_c;
            end
            AR: begin
               cnt <= cnt + CNT_W'(1);
               if (!bus.arready && to_hit_c) out_err <= 1'b1;
            end
            R: begin
               cnt <= cnt + CNT_W'(1);
               if (bus.rvalid) begin
                  read_data <= (bus.rresp == 2'b00) ? ext_c : 32'h0;
                  out_err   <= (bus.rresp != 2'b00);
               end else if (to_hit_c) begin
                  out_err <= 1'b1;
               end
            end
            AWW: begin
               cnt <= cnt + CNT_W'(1);
               if (bus.awvalid && bus.awready) aw_done <= 1'b1;
               if (bus.wvalid && bus.wready)   w_done  <= 1'b1;
               if (!(aw_fin_c && w_fin_c) && to_hit_c) out_err <= 1'b1;
            end
            B: begin
               cnt <= cnt + CNT_W'(1);
               if (bus.bvalid)    out_err <= (bus.bresp != 2'b00);
               else if (to_hit_c) out_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
